dvp_tx: RTL

//  DVP source: drives Vsync/Href/Data[7:0] with camera-compatible timing.

---
 rtl/dvp_tx_if.sv | 39 +++
 rtl/dvp_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dvp_tx_if.sv
// ---------------------------------------------------------------------------
// dvp_tx_if
//   Bundles the two buses that dvp_tx sits between: the upstream FWFT
//   FIFO read port and the downstream DVP pixel bus.
//
//   FIFO side : Pix_Data  (head byte), Pix_Valid (not empty), Pix_Rd (pop)
//   DVP side  : Vsync, Href, Data[7:0]
//
//   master : the DVP source (dvp_tx), which pops the FIFO and drives DVP.
//   slave  : the environment, which provides FIFO data and observes DVP.
// ---------------------------------------------------------------------------
interface dvp_tx_if;

    logic [7:0] Pix_Data;
    logic       Pix_Valid;
    logic       Pix_Rd;
    logic       Vsync;
    logic       Href;
    logic [7:0] Data;

    modport master (
        input  Pix_Data,
        input  Pix_Valid,
        output Pix_Rd,
        output Vsync,
        output Href,
        output Data
    );

    modport slave (
        output Pix_Data,
        output Pix_Valid,
        input  Pix_Rd,
        input  Vsync,
        input  Href,
        input  Data
    );

endinterface

// File: rtl/dvp_tx.sv
// ---------------------------------------------------------------------------
// dvp_tx
//   DVP sensor emulator. Generates Vsync/Href/Data with camera-style frame
//   timing; pixel bytes come either from an upstream FWFT FIFO or from an
//   internal test pattern (h_cnt + active line index).
//
//   Ports
//     PCLK        pixel clock, all logic on posedge
//     Rst_n       asynchronous, active-low reset
//     Tx_En       frame generation enable (checked only between frames)
//     Pat_Sel     0 = FIFO data, 1 = test pattern (latched at frame start)
//     Frame_Done  one-cycle pulse on the last cycle of the frame
//     Underrun    sticky, FIFO was empty on an active byte this frame
//     bus         dvp_tx_if.master: FIFO read port + DVP output bus
//
//   Vsync/Href/Data/Frame_Done/Underrun are registered and show the
//   FSM/counter state of the previous cycle. Pix_Rd is combinational so the
//   FWFT head byte can be captured into Data on the same edge as the pop.
// ---------------------------------------------------------------------------
module dvp_tx #(
    parameter int H_ACTIVE    = 1280,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic       PCLK,
    input  logic       Rst_n,
    input  logic       Tx_En,
    input  logic       Pat_Sel,
    output logic       Frame_Done,
    output logic       Underrun,
    dvp_tx_if.master   bus
);

    localparam int LP    = H_ACTIVE + H_BLANK;
    localparam int H_W   = (LP > 1) ? $clog2(LP) : 1;
    localparam int V_M01 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int V_M23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = (V_M01 > V_M23) ? V_M01 : V_M23;
    localparam int V_W   = (V_MAX > 1) ? $clog2(V_MAX) : 1;

    localparam logic [H_W-1:0] H_LAST    = H_W'(LP - 1);
    localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_t;

    state_t         state_q;
    logic [H_W-1:0] h_cnt_q;
    logic [V_W-1:0] v_cnt_q;
    logic           patMode_q;
    logic           vsync_q;
    logic           href_q;
    logic [7:0]     data_q;
    logic           frameDone_q;
    logic           underrun_q;

    logic           lineEnd;
    logic           lastLine;
    logic           actByte;
    logic [7:0]     hByte;
    logic [7:0]     vByte;
    logic [7:0]     data_d;

    // Position decode: end of the current line, and whether this line is the
    // last one the current state owns. v_cnt restarts at 0 in every state, so
    // each state compares against its own line count.
    assign lineEnd = (h_cnt_q == H_LAST);
    assign actByte = (state_q == ACTIVE) && (h_cnt_q < H_ACT_END);

    always_comb begin
        lastLine = 1'b0;
        case (state_q)
            VSYNC:   lastLine = (v_cnt_q == V_W'(VSYNC_LINES - 1));
            VBACK:   lastLine = (v_cnt_q == V_W'(V_BACK - 1));
            ACTIVE:  lastLine = (v_cnt_q == V_W'(V_ACTIVE - 1));
            VFRONT:  lastLine = (v_cnt_q == V_W'(V_FRONT - 1));
            default: lastLine = 1'b0;
        endcase
    end

    // Byte to present on Data next cycle. In ACTIVE, v_cnt is the active line
    // index, so the pattern is simply the low bytes of both counters summed.
    // An empty FIFO on an active byte yields 0 rather than stale head data.
    assign hByte = 8'(h_cnt_q);
    assign vByte = 8'(v_cnt_q);

    always_comb begin
        data_d = 8'h00;
        if (actByte) begin
            if (patMode_q) begin
                data_d = hByte + vByte;
            end else if (bus.Pix_Valid) begin
                data_d = bus.Pix_Data;
            end
        end
    end

    // Pop only on real FIFO-sourced active bytes; the pattern never reads.
    // During reset the FSM sits in IDLE, which forces this low.
    assign bus.Pix_Rd = actByte & ~patMode_q & bus.Pix_Valid;

    // Frame FSM, line/column counters and all registered outputs. The outputs
    // are computed from the current state so they land one cycle behind it,
    // keeping Vsync, Href, Data, Frame_Done and Underrun mutually aligned.
    // Tx_En is only looked at in IDLE and at the very end of VFRONT, which is
    // what guarantees a frame is never cut short. Pat_Sel is latched only on
    // the transition into VSYNC so a frame never mixes sources.
    always_ff @(posedge PCLK or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            patMode_q   <= 1'b0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= 8'h00;
            frameDone_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            vsync_q     <= (state_q == VSYNC);
            href_q      <= actByte;
            data_q      <= data_d;
            frameDone_q <= (state_q == VFRONT) && lineEnd && lastLine;

            // Cleared while in VSYNC so it reads 0 from the first Vsync
            // cycle of the new frame onward.
            if (state_q == VSYNC) begin
                underrun_q <= 1'b0;
            end else if (actByte && !patMode_q && !bus.Pix_Valid) begin
                underrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (Tx_En) begin
                        state_q   <= VSYNC;
                        patMode_q <= Pat_Sel;
                    end
                end
                default: begin
                    if (!lineEnd) begin
                        h_cnt_q <= h_cnt_q + H_W'(1);
                    end else begin
                        h_cnt_q <= '0;
                        if (!lastLine) begin
                            v_cnt_q <= v_cnt_q + V_W'(1);
                        end else begin
                            v_cnt_q <= '0;
                            case (state_q)
                                VSYNC:  state_q <= VBACK;
                                VBACK:  state_q <= ACTIVE;
                                ACTIVE: state_q <= VFRONT;
                                default: begin
                                    if (Tx_En) begin
                                        state_q   <= VSYNC;
                                        patMode_q <= Pat_Sel;
                                    end else begin
                                        state_q <= IDLE;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign bus.Vsync  = vsync_q;
    assign bus.Href   = href_q;
    assign bus.Data   = data_q;
    assign Frame_Done = frameDone_q;
    assign Underrun   = underrun_q;

endmodule
